// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and constants for the round-robin select arbiter.
// Holds FSM state encoding, channel/select widths, pointer reset, output bundle.
package rr_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_RST = 2'b11;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  grant;
    logic             busy;
  } arb_out_t;

  function automatic logic [N_CH-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational rotated-priority search over four requests.
// Ports: req[3:0], last[1:0] in; win[1:0] (first set bit from last+1), any out.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0]  base;
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W-1:0]  off;

  // Rotate so bit 0 of rot is channel last+1; the
  // 2-bit adds below give the mod-4 wrap for free.
  always_comb begin
    base = last + 2'd1;
    dbl  = {req, req} >> base;
    rot  = dbl[N_CH-1:0];
    off  = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    win = base + off;
    any = |req;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 4-channel round-robin arbiter driving a 4:1 mux select.
// Ports: clk, rst (sync, active-high), req[3:0], done -> sel[1:0], grant[3:0],
// busy, timeout. Macro RR_ARB_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             busy,
  output logic             timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 2..255");
  end

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] last_nx;
  arb_out_t         q;
  arb_out_t         d;
  logic [SEL_W-1:0] win;
  logic             any;

  rr_pick u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       to_q;
  logic       to_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= LAST_RST;
      q.sel   <= '0;
      q.grant <= '0;
      q.busy  <= 1'b0;
    end else begin
      last <= last_nx;
      q    <= d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      to_q <= to_nx;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    last_nx  = last;
    d        = q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_nx   = cnt;
    to_nx    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        d.grant = '0;
        if (any) begin
          d.sel    = win;
          d.grant  = onehot(win);
          d.busy   = 1'b1;
          last_nx  = win;
          state_nx = ST_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (done) begin
          d.grant  = '0;
          d.busy   = 1'b0;
          state_nx = ST_IDLE;
`ifdef RR_ARB_TIMEOUT_EN
        end else if (cnt == LIM) begin
          // Watchdog release; done has priority above.
          d.grant  = '0;
          d.busy   = 1'b0;
          to_nx    = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx   = cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign sel   = q.sel;
  assign grant = q.grant;
  assign busy  = q.busy;

`ifdef RR_ARB_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed + random bench with a behavioural arbiter model.
// Checks every cycle against the model plus literal expectations.
module tb_rr_sel_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_sel_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: owner = granted channel or -1 when idle.
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_age   = 0;
  int m_to    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_age   = 0;
      m_to    = 0;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (req[c] && m_owner < 0) m_owner = c;
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_sel  = m_owner;
          m_age  = 0;
        end
      end else begin
        if (done) m_owner = -1;
`ifdef RR_ARB_TIMEOUT_EN
        else if (m_age == TO - 1) begin
          m_owner = -1;
          m_to    = 1;
        end else m_age++;
`endif
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_sel", sel, m_sel);
      cmp("m_grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
      cmp("m_busy", busy, (m_owner >= 0) ? 1 : 0);
      cmp("m_timeout", timeout, m_to);
    end
  end

  task automatic wait_busy();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_grant: got busy=0 expected busy=1 within 20 cycles");
    end
  endtask

  task automatic serve(input int es, input logic [3:0] nreq);
    wait_busy();
    cmp("g_sel", sel, es);
    cmp("g_grant", grant, 1 << es);
    req = nreq;
    repeat (2) @(negedge clk);
    cmp("hold_sel", sel, es);
    cmp("hold_grant", grant, 1 << es);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cmp("rel_busy", busy, 0);
    cmp("rel_grant", grant, 0);
  endtask

  initial begin
    int hi;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    cmp("rst_sel", sel, 0);
    cmp("rst_grant", grant, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_to", timeout, 0);
    rst = 1'b0;

    // Full rotation with all channels requesting.
    req = 4'b1111;
    serve(0, 4'b1111);
    serve(1, 4'b1111);
    serve(2, 4'b1111);
    serve(3, 4'b1111);
    serve(0, 4'b0000);

    // Wrap 3 -> 0 after a ch2 grant.
    req = 4'b0100;
    serve(2, 4'b0101);
    serve(0, 4'b0101);
    serve(2, 4'b0000);

    // Request changes during grant are ignored.
    req = 4'b0010;
    serve(1, 4'b1000);
    @(negedge clk);
    cmp("regrant_busy", busy, 1);
    cmp("regrant_sel", sel, 3);
    cmp("regrant_grant", grant, 4'b1000);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    // done in IDLE after reset does nothing.
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    cmp("idle_sel", sel, 0);
    cmp("idle_grant", grant, 0);
    cmp("idle_busy", busy, 0);

    // Reset mid-grant drops the grant.
    req = 4'b0100;
    wait_busy();
    cmp("pre_rst_sel", sel, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("mid_rst_grant", grant, 0);
    cmp("mid_rst_busy", busy, 0);
    cmp("mid_rst_sel", sel, 0);
    cmp("mid_rst_to", timeout, 0);
    rst = 1'b0;
    wait_busy();
    cmp("post_rst_sel", sel, 2);
    cmp("post_rst_grant", grant, 4'b0100);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);

`ifdef RR_ARB_TIMEOUT_EN
    // Watchdog release after TO grant cycles.
    req = 4'b0001;
    wait_busy();
    req = 4'b0000;
    hi  = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      hi++;
    end
    cmp("to_cycles", hi, 4);
    cmp("to_pulse", timeout, 1);
    @(negedge clk);
    cmp("to_pulse_end", timeout, 0);
    // done on the limit cycle wins.
    req = 4'b0001;
    wait_busy();
    req = 4'b0000;
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cmp("tie_busy", busy, 0);
    cmp("tie_to", timeout, 0);
    @(negedge clk);
`else
    hi = 0;
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req  = 4'($urandom);
      done = ($urandom_range(3) == 0);
      rst  = ($urandom_range(99) == 0);
    end
    rst  = 1'b0;
    done = 1'b0;
    req  = 4'b0000;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
